// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the three-port SDRAM arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] ID_VID = 2'd0;
  localparam logic [1:0] ID_DAT = 2'd1;
  localparam logic [1:0] ID_FET = 2'd2;

  localparam int GUARD_DEF     = 2;
  localparam int TIMEOUT_DEF   = 255;
  localparam int VID_BURST_DEF = 4;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational grant picker: bounded video priority, data/fetch round-robin
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int VID_BURST = VID_BURST_DEF,
  parameter int VW        = 3
) (
  input  logic          vid_req,
  input  logic          d_req,
  input  logic          f_req,
  input  logic          rr,
  input  logic [VW-1:0] vid_cnt,
  output logic          gnt_valid,
  output logic [1:0]    gnt_id
);

  logic vid_blocked;

  // Video yields only once its burst is used up and the CPU is actually waiting.
  assign vid_blocked = (vid_cnt == VW'(VID_BURST)) && (d_req || f_req);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ID_VID;
    if (vid_req && !vid_blocked) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_VID;
    end else if (d_req && f_req) begin
      gnt_valid = 1'b1;
      gnt_id    = rr ? ID_FET : ID_DAT;
    end else if (d_req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_DAT;
    end else if (f_req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_FET;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one SDRAM core port between video, CPU data and CPU fetch
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int GUARD     = GUARD_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int VID_BURST = VID_BURST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [22:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [22:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  input  logic        f_req,
  input  logic [22:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int VW = (VID_BURST > 1) ? $clog2(VID_BURST + 1) : 1;

  state_t        state, state_nxt;
  logic [1:0]    cur_id;
  logic          cur_we;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] wcnt;
  logic [VW-1:0] vid_cnt;
  logic          rr;
  logic          pick_valid;
  logic [1:0]    pick_id;
  logic          done, tmo;
  logic [15:0]   rd_data;

  assign busy = (state != S_IDLE);

  // A requester being acked this cycle still shows its old req; keep it out of arbitration.
  sdram_arb_pick #(.VID_BURST(VID_BURST), .VW(VW)) u_pick (
    .vid_req   (vid_req && !vid_ack),
    .d_req     (d_req && !d_ack),
    .f_req     (f_req && !f_ack),
    .rr        (rr),
    .vid_cnt   (vid_cnt),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tmo       = 1'b0;
    rd_data   = mem_rdata;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_GUARD;
      S_GUARD: if (gcnt == GW'(GUARD - 1)) state_nxt = S_WAIT;
      S_WAIT: begin
        tmo  = !mem_ready && (wcnt == TW'(TIMEOUT));
        done = mem_ready || tmo;
        if (tmo) rd_data = 16'hFFFF;
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_id      <= ID_VID;
      cur_we      <= 1'b0;
      gcnt        <= '0;
      wcnt        <= '0;
      vid_cnt     <= '0;
      rr          <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      vid_ack     <= 1'b0;
      d_ack       <= 1'b0;
      f_ack       <= 1'b0;
      vid_rdata   <= '0;
      d_rdata     <= '0;
      f_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      vid_ack <= 1'b0;
      d_ack   <= 1'b0;
      f_ack   <= 1'b0;
      case (state)
        S_IDLE: if (pick_valid) begin
          cur_id    <= pick_id;
          cur_we    <= (pick_id == ID_DAT) && d_we;
          mem_we    <= (pick_id == ID_DAT) && d_we;
          mem_wdata <= d_wdata;
          gcnt      <= '0;
          wcnt      <= '0;
          case (pick_id)
            ID_VID:  mem_addr <= vid_addr;
            ID_DAT:  mem_addr <= d_addr;
            default: mem_addr <= f_addr;
          endcase
          if (pick_id == ID_VID) begin
            if (vid_cnt != VW'(VID_BURST)) vid_cnt <= vid_cnt + 1'b1;
          end else begin
            vid_cnt <= '0;
            rr      <= (pick_id == ID_DAT);
          end
        end
        S_GUARD: gcnt <= gcnt + 1'b1;
        S_WAIT: begin
          if (done) begin
            mem_we <= 1'b0;
            if (tmo) timeout_err <= 1'b1;
            case (cur_id)
              ID_VID: begin
                vid_ack   <= 1'b1;
                vid_rdata <= rd_data;
              end
              ID_DAT: begin
                d_ack <= 1'b1;
                if (!cur_we) d_rdata <= rd_data;
              end
              default: begin
                f_ack   <= 1'b1;
                f_rdata <= rd_data;
              end
            endcase
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
